// File: rtl/pe_vec_acc.sv
// Vector processing element: per-lane add/sub/multiply, adder-tree reduction,
// and a MAC accumulator stage behind a single valid/ready pipeline.

module pe_vec_lane #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 75
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic [1:0]           op,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [ACC_WIDTH-1:0] res
);
  // One extra bit makes signed and unsigned operands share one signed datapath.
  logic signed [WIDTH:0]       xs, ys;
  logic signed [2*WIDTH+1:0]   prod;
  logic        [ACC_WIDTH-1:0] xe, ye, r;

  always_comb begin
    xs   = {sgn & x[WIDTH-1], x};
    ys   = {sgn & y[WIDTH-1], y};
    prod = xs * ys;
    xe   = {{(ACC_WIDTH-WIDTH-1){xs[WIDTH]}}, xs};
    ye   = {{(ACC_WIDTH-WIDTH-1){ys[WIDTH]}}, ys};
    case (op)
      2'b00:   r = xe + ye;
      2'b01:   r = xe - ye;
      default: r = {{(ACC_WIDTH-2*WIDTH-2){prod[2*WIDTH+1]}}, prod};
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)   res <= '0;
    else if (en) res <= r;
  end
endmodule

module pe_vec_acc #(
  parameter  int WIDTH     = 32,
  parameter  int LANES     = 8,
  localparam int LOG_L     = $clog2(LANES),
  localparam int ACC_WIDTH = 2*WIDTH + LOG_L + 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [LANES*WIDTH-1:0] io_x,
  input  logic [LANES*WIDTH-1:0] io_y,
  input  logic [1:0]             io_op_type,
  input  logic                   io_use_int_signed,
  input  logic                   io_acc_clear,
  input  logic                   io_last,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [ACC_WIDTH-1:0]   io_out_data,
  output logic                   io_busy,
  output logic [15:0]            io_beats
);
  typedef struct packed {
    logic [1:0] op;
    logic       clear;
    logic       last;
  } ctl_t;

  logic                              advance, accept;
  logic [2:1]                        vld_pipe;
  ctl_t                              ctl1, ctl2;
  logic [LANES-1:0][ACC_WIDTH-1:0]   lane_res;
  logic [ACC_WIDTH-1:0]              tree_sum, sum2, acc, mac_sum;

  assign advance     = !io_out_valid || io_out_ready;
  assign io_in_ready = advance;
  assign accept      = io_in_valid && advance;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_vec_lane #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clock (clock),
      .reset (reset),
      .en    (accept),
      .op    (io_op_type),
      .sgn   (io_use_int_signed),
      .x     (io_x[i*WIDTH +: WIDTH]),
      .y     (io_y[i*WIDTH +: WIDTH]),
      .res   (lane_res[i])
    );
  end

  // Balanced reduction: level l holds LANES>>l partial sums.
  for (genvar l = 0; l <= LOG_L; l++) begin : g_lvl
    logic [(LANES>>l)-1:0][ACC_WIDTH-1:0] s;
    if (l == 0) begin : g_leaf
      assign s = lane_res;
    end else begin : g_node
      for (genvar j = 0; j < (LANES>>l); j++) begin : g_add
        assign s[j] = g_lvl[l-1].s[2*j] + g_lvl[l-1].s[2*j+1];
      end
    end
  end
  assign tree_sum = g_lvl[LOG_L].s[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      ctl1     <= '0;
      ctl2     <= '0;
      sum2     <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[1], accept};
      if (accept)      ctl1 <= '{op: io_op_type, clear: io_acc_clear, last: io_last};
      if (vld_pipe[1]) begin
        ctl2 <= ctl1;
        sum2 <= tree_sum;
      end
    end
  end

  assign mac_sum = (ctl2.clear ? '0 : acc) + sum2;

  always_ff @(posedge clock) begin
    if (reset) begin
      io_out_valid <= 1'b0;
      io_out_data  <= '0;
      acc          <= '0;
      io_busy      <= 1'b0;
      io_beats     <= '0;
    end else if (advance) begin
      io_out_valid <= 1'b0;
      if (vld_pipe[2]) begin
        if (ctl2.op != 2'b11) begin
          io_out_data  <= sum2;
          io_out_valid <= 1'b1;
        end else if (ctl2.last) begin
          io_out_data  <= mac_sum;
          io_out_valid <= 1'b1;
          acc          <= '0;
          io_busy      <= 1'b0;
          io_beats     <= '0;
        end else begin
          acc      <= mac_sum;
          io_busy  <= 1'b1;
          io_beats <= ctl2.clear ? 16'd1 :
                      (io_beats == 16'hFFFF) ? io_beats : io_beats + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pe_vec_acc.sv
// Bench for pe_vec_acc: directed vector table, MAC/stall/reset sequences and
// randomized traffic checked against an arithmetic reference scoreboard.

module tb_pe_vec_acc;
  localparam int W = 32;
  localparam int L = 8;
  localparam int A = 2*W + 3 + 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready;
  logic [L*W-1:0] x, y;
  logic [1:0]     op;
  logic           sgn, clr, last;
  logic           out_valid, out_ready;
  logic [A-1:0]   out_data;
  logic           busy;
  logic [15:0]    beats;

  always #5 clk = ~clk;

  pe_vec_acc #(.WIDTH(W), .LANES(L)) dut (
    .clock             (clk),
    .reset             (rst),
    .io_in_valid       (in_valid),
    .io_in_ready       (in_ready),
    .io_x              (x),
    .io_y              (y),
    .io_op_type        (op),
    .io_use_int_signed (sgn),
    .io_acc_clear      (clr),
    .io_last           (last),
    .io_out_valid      (out_valid),
    .io_out_ready      (out_ready),
    .io_out_data       (out_data),
    .io_busy           (busy),
    .io_beats          (beats)
  );

  typedef struct {
    logic [1:0]     op;
    logic           sgn, clr, last;
    logic [L*W-1:0] x, y;
  } beat_t;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic         sgn;
    logic [W-1:0] xv, yv;
    logic [A-1:0] exp;
  } vec_t;

  int           total = 0;
  int           bad   = 0;
  logic [A-1:0] expq[$];
  logic [A-1:0] m_acc = '0;
  bit           sb_on = 1'b0;
  bit           done  = 1'b0;

  task automatic chk(string nm, logic [A-1:0] act, logic [A-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [A-1:0] ext(logic [W-1:0] v, logic s);
    return s ? {{(A-W){v[W-1]}}, v} : {{(A-W){1'b0}}, v};
  endfunction

  function automatic logic [A-1:0] beat_val(beat_t b);
    logic [A-1:0] s = '0;
    for (int i = 0; i < L; i++) begin
      logic [A-1:0] xe = ext(b.x[i*W +: W], b.sgn);
      logic [A-1:0] ye = ext(b.y[i*W +: W], b.sgn);
      case (b.op)
        2'b00:   s = s + xe + ye;
        2'b01:   s = s + xe - ye;
        default: s = s + xe * ye;
      endcase
    end
    return s;
  endfunction

  task automatic model(beat_t b);
    logic [A-1:0] v = beat_val(b);
    if (b.op != 2'b11) expq.push_back(v);
    else begin
      if (b.clr) m_acc = '0;
      m_acc = m_acc + v;
      if (b.last) begin
        expq.push_back(m_acc);
        m_acc = '0;
      end
    end
  endtask

  // Scoreboard: every transfer is popped in order; held data must not move.
  logic [A-1:0] prev_data;
  bit           prev_hold = 1'b0;
  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (prev_hold) chk("hold_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_extra got=%0h want=none", out_data);
        end else chk("sb_data", out_data, expq.pop_front());
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end else prev_hold = 1'b0;
  end

  // Present a beat until the handshake completes, then hand it to the model.
  task automatic send(beat_t b);
    int n = 0;
    op = b.op; sgn = b.sgn; clr = b.clr; last = b.last; x = b.x; y = b.y;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        model(b);
        break;
      end
      @(posedge clk);
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL send_timeout got=stalled want=accepted");
        break;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  function automatic beat_t mk(logic [1:0] o, logic s, logic c, logic la,
                               logic [W-1:0] xv, logic [W-1:0] yv);
    beat_t b;
    b.op = o; b.sgn = s; b.clr = c; b.last = la;
    b.x = {L{xv}}; b.y = {L{yv}};
    return b;
  endfunction

  // Single beat with an idle pipeline and out_ready high: result on the third edge.
  task automatic run_lat(string nm, beat_t b, logic [A-1:0] exp);
    send(b);
    @(negedge clk); chk({nm, "_v1"}, A'(out_valid), A'(0));
    @(negedge clk); chk({nm, "_v2"}, A'(out_valid), A'(0));
    @(negedge clk); chk({nm, "_v3"}, A'(out_valid), A'(1));
    chk({nm, "_data"}, out_data, exp);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (expq.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("drain_empty", A'(expq.size()), A'(0));
  endtask

  vec_t  vt[8];
  beat_t b;

  initial begin
    vt[0] = '{"dot_u_3x5",  2'b10, 1'b0, 32'd3,        32'd5,        A'(120)};
    vt[1] = '{"sub_s_0m1",  2'b01, 1'b1, 32'd0,        32'd1,        A'(0) - A'(8)};
    vt[2] = '{"dot_u_max",  2'b10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
              A'(8) * A'(32'hFFFFFFFF) * A'(32'hFFFFFFFF)};
    vt[3] = '{"add_u_7p9",  2'b00, 1'b0, 32'd7,        32'd9,        A'(128)};
    vt[4] = '{"dot_s_m1x2", 2'b10, 1'b1, 32'hFFFFFFFF, 32'd2,        A'(0) - A'(16)};
    vt[5] = '{"add_s_min",  2'b00, 1'b1, 32'h80000000, 32'h80000000, A'(0) - (A'(1) << 35)};
    vt[6] = '{"add_u_max1", 2'b00, 1'b0, 32'hFFFFFFFF, 32'd1,        A'(1) << 35};
    vt[7] = '{"sub_u_0m1",  2'b01, 1'b0, 32'd0,        32'd1,        A'(0) - A'(8)};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; sgn = 1'b0; clr = 1'b0; last = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", A'(out_valid), A'(0));
    chk("rst_out_data",  out_data,      A'(0));
    chk("rst_busy",      A'(busy),      A'(0));
    chk("rst_beats",     A'(beats),     A'(0));
    chk("rst_in_ready",  A'(in_ready),  A'(1));
    sb_on = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_lat(vt[i].name, mk(vt[i].op, vt[i].sgn, 1'b0, 1'b0, vt[i].xv, vt[i].yv), vt[i].exp);

    // Three MAC beats of 8 lanes * 1 * 2: partial sums 16, 32, emitted total 48.
    send(mk(2'b11, 1'b0, 1'b1, 1'b0, 32'd1, 32'd2));
    send(mk(2'b11, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2));
    send(mk(2'b11, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2));
    @(negedge clk);
    chk("mac_beats1", A'(beats), A'(1));
    chk("mac_busy1",  A'(busy),  A'(1));
    chk("mac_nout1",  A'(out_valid), A'(0));
    @(negedge clk);
    chk("mac_beats2", A'(beats), A'(2));
    chk("mac_nout2",  A'(out_valid), A'(0));
    @(negedge clk);
    chk("mac_out_v",  A'(out_valid), A'(1));
    chk("mac_out_d",  out_data, A'(48));
    chk("mac_beats0", A'(beats), A'(0));
    chk("mac_busy0",  A'(busy),  A'(0));
    @(posedge clk); #1;

    // Non-MAC beat in the middle of an accumulation passes straight through.
    send(mk(2'b11, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1));
    send(mk(2'b00, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1));
    send(mk(2'b11, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1));
    drain();

    // Consumer stalls with three results in flight and a fourth beat waiting.
    out_ready = 1'b0;
    send(mk(2'b10, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5));
    send(mk(2'b00, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2));
    send(mk(2'b01, 1'b1, 1'b0, 1'b0, 32'd1, 32'd4));
    fork
      send(mk(2'b10, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 32'd3));
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_in_ready", A'(in_ready),  A'(0));
          chk("stall_valid",    A'(out_valid), A'(1));
          chk("stall_data",     out_data,      A'(120));
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset while a partial sum is held and two MAC beats are in flight.
    send(mk(2'b11, 1'b0, 1'b1, 1'b0, 32'd5, 32'd5));
    send(mk(2'b11, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5));
    send(mk(2'b11, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5));
    @(negedge clk);
    chk("pre_rst_busy", A'(busy), A'(1));
    #1 rst = 1'b1;
    expq.delete();
    m_acc = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", A'(out_valid), A'(0));
    chk("mrst_out_data",  out_data,      A'(0));
    chk("mrst_busy",      A'(busy),      A'(0));
    chk("mrst_beats",     A'(beats),     A'(0));
    chk("mrst_in_ready",  A'(in_ready),  A'(1));
    @(posedge clk); #1;
    run_lat("post_rst_dot", mk(2'b10, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5), A'(120));
    run_lat("post_rst_mac", mk(2'b11, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1), A'(8));

    // Random traffic with random consumer back-pressure.
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          beat_t rb;
          rb.op  = 2'($urandom_range(0, 3));
          rb.sgn = 1'($urandom_range(0, 1));
          rb.clr = ($urandom_range(0, 3) == 0);
          rb.last = ($urandom_range(0, 2) == 0);
          for (int i = 0; i < L; i++) begin
            rb.x[i*W +: W] = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 15));
            rb.y[i*W +: W] = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 15));
          end
          send(rb);
          if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
